// File: rtl/cpu_run_ctrl_if.sv
// Control/observation bundle between a run controller and the bench or top-level logic.
// The slave side is the controller; the master side drives start and the CPU pc/inst taps.
interface cpu_run_ctrl_if #(
    parameter int ADDR_LEN  = 32,
    parameter int INSTR_LEN = 32,
    parameter int CNT_W     = 16
);
    logic                 start;
    logic [ADDR_LEN-1:0]  pc;
    logic [INSTR_LEN-1:0] inst;
    logic                 cpu_rst;
    logic                 busy;
    logic                 done;
    logic                 halted;
    logic                 timeout;
    logic [CNT_W-1:0]     cycle_cnt;
    logic [ADDR_LEN-1:0]  final_pc;
    logic [INSTR_LEN-1:0] final_inst;

    modport master (
        output start, pc, inst,
        input  cpu_rst, busy, done, halted, timeout, cycle_cnt, final_pc, final_inst
    );

    modport slave (
        input  start, pc, inst,
        output cpu_rst, busy, done, halted, timeout, cycle_cnt, final_pc, final_inst
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run controller for a single-cycle CPU: sequences the core reset, watches pc for a
// halt loop or an exhausted cycle budget, and holds sticky completion status.
module cpu_run_ctrl #(
    parameter int ADDR_LEN    = 32,
    parameter int INSTR_LEN   = 32,
    parameter int RST_CYCLES  = 1,
    parameter int MAX_CYCLES  = 20,
    parameter int HALT_REPEAT = 4,
    parameter int CNT_W       = 16
) (
    input  logic           clk,
    input  logic           rst,
    cpu_run_ctrl_if.slave  bus
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [RC_W-1:0]      rst_cnt, rst_cnt_nxt;
    logic [CNT_W-1:0]     cycle_cnt, cycle_nxt;
    logic [CNT_W-1:0]     stall_cnt, stall_nxt;
    logic [ADDR_LEN-1:0]  prev_pc, prev_pc_nxt;
    logic [ADDR_LEN-1:0]  final_pc, final_pc_nxt;
    logic [INSTR_LEN-1:0] final_inst, final_inst_nxt;
    logic                 first_run, first_run_nxt;
    logic                 halted, halted_nxt;
    logic                 timeout, timeout_nxt;
    logic                 halt_hit, budget_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        rst_cnt_nxt    = rst_cnt;
        cycle_nxt      = cycle_cnt;
        stall_nxt      = stall_cnt;
        prev_pc_nxt    = prev_pc;
        first_run_nxt  = first_run;
        halted_nxt     = halted;
        timeout_nxt    = timeout;
        final_pc_nxt   = final_pc;
        final_inst_nxt = final_inst;
        halt_hit       = 1'b0;
        budget_hit     = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nxt   = RESET;
                    rst_cnt_nxt = '0;
                    cycle_nxt   = '0;
                    stall_nxt   = '0;
                    halted_nxt  = 1'b0;
                    timeout_nxt = 1'b0;
                end
            end

            RESET: begin
                rst_cnt_nxt = rst_cnt + RC_W'(1);
                if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
                    state_nxt     = RUN;
                    first_run_nxt = 1'b1;
                end
            end

            RUN: begin
                cycle_nxt     = sat_inc(cycle_cnt);
                prev_pc_nxt   = bus.pc;
                first_run_nxt = 1'b0;
                // prev_pc is stale on the first RUN cycle, so no comparison is made there
                if (first_run) begin
                    stall_nxt = '0;
                end else if (bus.pc == prev_pc) begin
                    stall_nxt = sat_inc(stall_cnt);
                end else begin
                    stall_nxt = '0;
                end

                halt_hit   = (stall_nxt == CNT_W'(HALT_REPEAT));
                budget_hit = (cycle_nxt == CNT_W'(MAX_CYCLES));
                if (halt_hit || budget_hit) begin
                    state_nxt      = DONE;
                    halted_nxt     = halt_hit;
                    timeout_nxt    = !halt_hit;
                    final_pc_nxt   = bus.pc;
                    final_inst_nxt = bus.inst;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_cnt    <= '0;
            cycle_cnt  <= '0;
            stall_cnt  <= '0;
            prev_pc    <= '0;
            first_run  <= 1'b0;
            halted     <= 1'b0;
            timeout    <= 1'b0;
            final_pc   <= '0;
            final_inst <= '0;
        end else begin
            rst_cnt    <= rst_cnt_nxt;
            cycle_cnt  <= cycle_nxt;
            stall_cnt  <= stall_nxt;
            prev_pc    <= prev_pc_nxt;
            first_run  <= first_run_nxt;
            halted     <= halted_nxt;
            timeout    <= timeout_nxt;
            final_pc   <= final_pc_nxt;
            final_inst <= final_inst_nxt;
        end
    end

    // Decoded from state so cpu_rst rises as soon as rst drops, with no clock needed
    assign bus.cpu_rst    = (state != RUN);
    assign bus.busy       = (state == RESET) || (state == RUN);
    assign bus.done       = (state == DONE);
    assign bus.halted     = halted;
    assign bus.timeout    = timeout;
    assign bus.cycle_cnt  = cycle_cnt;
    assign bus.final_pc   = final_pc;
    assign bus.final_inst = final_inst;

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Synthesizable run controller that sequences a CPU core's reset, supervises execution, and reports completion. It is the parametrised successor to the fixed-length simulation bench: configurable reset length, cycle budget and halt detection, with sticky status outputs. It sits between top-level control or bench logic and single_period_cpu: it drives the CPU reset and observes its pc/inst buses.

Parameters:
ADDR_LEN, 32, width of the observed pc bus
INSTR_LEN, 32, width of the observed inst bus
RST_CYCLES, 1, cycles cpu_rst is held high after start (>=1)
MAX_CYCLES, 20, run-cycle budget before timeout (>=1)
HALT_REPEAT, 4, consecutive cycles pc must stay unchanged to declare halt (>=1)
CNT_W, 16, width of cycle_cnt and stall counter; must hold MAX_CYCLES

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; begins a run from IDLE or DONE
pc  in  ADDR_LEN  CPU program counter
inst  in  INSTR_LEN  CPU current instruction
cpu_rst  out  1  active-high reset to the CPU
busy  out  1  high in RESET and RUN
done  out  1  sticky, run finished
halted  out  1  sticky, finished by halt detection
timeout  out  1  sticky, finished by cycle budget
cycle_cnt  out  CNT_W  RUN cycles elapsed
final_pc  out  ADDR_LEN  pc captured at finish
final_inst  out  INSTR_LEN  inst captured at finish

Behaviour:
- Reset (rst=0, async): state=IDLE, cpu_rst=1, busy=0, done=0, halted=0, timeout=0, cycle_cnt=0, final_pc=0, final_inst=0, internal prev_pc=0 and stall_cnt=0.
- FSM states: IDLE, RESET, RUN, DONE.
- IDLE: cpu_rst=1. start=1 -> RESET. Load rst_cnt=0.
- RESET: cpu_rst=1, busy=1. rst_cnt increments each cycle. When rst_cnt==RST_CYCLES-1 -> RUN. cpu_rst is therefore high for exactly RST_CYCLES cycles.
- Entry from IDLE or DONE into RESET clears done, halted, timeout, cycle_cnt and stall_cnt in the same edge.
- RUN: cpu_rst=0, busy=1. Each cycle: cycle_cnt+=1 and prev_pc<=pc. If pc==prev_pc, stall_cnt+=1; otherwise stall_cnt<=0.
- RUN, first cycle: prev_pc is loaded from pc, and stall_cnt is not incremented.
- Halt: when the next stall_cnt value equals HALT_REPEAT -> DONE with halted=1.
- Timeout: when the next cycle_cnt value equals MAX_CYCLES -> DONE with timeout=1.
- Both conditions in the same cycle: halted=1, timeout=0 (halt has priority).
- Transition into DONE: final_pc<=pc and final_inst<=inst, sampled on the same edge.
- DONE: cpu_rst=1 (CPU frozen), busy=0, done=1, and flags plus captures are held.
- DONE with start=1 -> RESET (rerun).
- start while RESET or RUN: ignored, with no restart.
- cycle_cnt saturates at all-ones; it cannot overflow when MAX_CYCLES fits CNT_W.
- rst asserted mid-run: immediate return to reset values; cpu_rst asserts asynchronously.
- inst is observed only for capture; it does not affect control.

Test Plan:
- Reset then idle: rst low 2 cycles, released, no start -> cpu_rst=1, busy=0, done=0, all counters 0 indefinitely.
- Timeout run: RST_CYCLES=1, MAX_CYCLES=20, pc increments by 4 each cycle; start pulse -> cpu_rst high 1 cycle; after 20 RUN cycles done=1, timeout=1, halted=0, cycle_cnt=20, final_pc = pc at the 20th edge.
- Halt run: HALT_REPEAT=4; pc runs 0,4,8,12 then sticks at 12 -> done after the 4th repeated 12; halted=1, timeout=0, final_pc=12, cycle_cnt=8.
- Simultaneous halt/timeout: MAX_CYCLES=5, HALT_REPEAT=4, pc constant from the first RUN cycle -> the halt-completing cycle coincides with cycle 5; halted=1, timeout=0.
- Rerun and ignored start: start pulsed during RUN -> no effect. Start in DONE -> flags clear next edge, cpu_rst high RST_CYCLES=3 cycles, and a new run completes with fresh counts.
- Async reset mid-RUN: drop rst at cycle 7 between clock edges -> cpu_rst=1 and busy=0 immediately, without waiting for a clock edge; after release, state=IDLE and cycle_cnt=0.
